// File: rtl/sat_add_seq.sv
// sat_add_seq
//   Sequencer around an external 3-input saturating adder.
//
//   Operation:
//   - Partial products arrive on a valid/ready stream.
//   - They are gathered three at a time into the registered adder operands.
//   - The adder settles for one ADD cycle.
//   - Its clamped sum is then captured into a one-deep output register.
//   - Delivered results are counted per frame.
//   - done pulses after the last result of a frame.
//
//   Handshake rule, used on both streams:
//   - A transfer happens on a rising edge where valid and ready are both high.
//   - A producer holds valid and its data until that transfer.
//   - The consumer never retracts ready within the cycle.
//   - out_data/out_valid are registers.
//   - pp_ready is a pure decode of the state register.
//   - Neither depends combinationally on the other side's valid/ready.
//
//   Ports:
//     clk, rst            clock; asynchronous active-high reset
//     start               frame start, acted on only in IDLE
//     pp_valid/pp_data    partial-product stream in (signed, passed verbatim)
//     pp_ready            high only while collecting
//     add_in0..2          registered adder operands
//     add_sum             combinational saturated sum from the adder
//     out_valid/out_data  captured result, held until out_ready
//     out_ready           downstream accept
//     busy                high in every state except IDLE
//     done                one-cycle pulse after the last result of a frame
//     pix_cnt             results delivered in the current frame
//     dbg_state           current FSM state, for checkers and debug
module sat_add_seq #(
  parameter int DATA_BITS = 9,
  parameter int PP_W      = 20,
  parameter int NUM_PIX   = 64,
  parameter int CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pp_valid,
  input  logic [PP_W-1:0]      pp_data,
  output logic                 pp_ready,
  output logic [PP_W-1:0]      add_in0,
  output logic [PP_W-1:0]      add_in1,
  output logic [PP_W-1:0]      add_in2,
  input  logic [DATA_BITS-1:0] add_sum,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     pix_cnt,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_ADD     = 3'd2;
  localparam logic [2:0] S_OUT     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NUM_PIX - 1);

  logic [2:0] state;
  logic [2:0] next_state;
  logic [1:0] slot;
  logic       pp_hs;
  logic       out_hs;

  // Status outputs are decodes of the state register, so they are glitch-free
  // and read 0 while reset is asserted.
  assign pp_ready  = (state == S_COLLECT);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

  assign pp_hs  = pp_valid & pp_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (pp_hs && slot == 2'd2) next_state = S_ADD;
      end
      S_ADD: begin
        next_state = S_OUT;
      end
      S_OUT: begin
        // pix_cnt still holds the pre-increment count here.
        if (out_hs) next_state = (pix_cnt == LAST_PIX) ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        // start is deliberately not looked at; a new frame needs IDLE.
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Slot index selects which operand register the next accepted product fills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= 2'd0;
    end else if (state == S_IDLE && start) begin
      slot <= 2'd0;
    end else if (pp_hs) begin
      slot <= (slot == 2'd2) ? 2'd0 : slot + 2'd1;
    end
  end

  // Operands are only written by accepted products. They stay put through ADD
  // and OUT so the adder output is stable when sampled, and they are not
  // cleared between groups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_in0 <= '0;
      add_in1 <= '0;
      add_in2 <= '0;
    end else if (pp_hs) begin
      case (slot)
        2'd0:    add_in0 <= pp_data;
        2'd1:    add_in1 <= pp_data;
        default: add_in2 <= pp_data;
      endcase
    end
  end

  // One-deep result register. Clamping is the adder's job; the sum is
  // captured verbatim at the end of the ADD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == S_ADD) begin
      out_valid <= 1'b1;
      out_data  <= add_sum;
    end else if (state == S_OUT && out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Per-frame result counter; cleared on an honoured start, bumped on each
  // delivered result, and left at NUM_PIX after the frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      pix_cnt <= '0;
    end else if (state == S_OUT && out_hs) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

endmodule
